// File: rtl/gbuff_hub_pkg.sv
// rtl/gbuff_hub_pkg.sv - shared types and defaults for the global-buffer hub
package gbuff_hub_pkg;

    // Defaults track the core's word size and buffer index range
    localparam int GB_WORD_W = 32;
    localparam int GB_DEPTH  = 256;

    localparam logic DIR_LOAD = 1'b0;
    localparam logic DIR_DUMP = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DUMP = 2'd2,
        DONE = 2'd3
    } hub_state_t;

endpackage

// File: rtl/gbuff_bank.sv
// rtl/gbuff_bank.sv - single-port bank with registered read; parity slice under GBUFF_PARITY_EN
module gbuff_bank #(
    parameter int WORD_W = 32,
    parameter int DEPTH  = 256,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [WORD_W-1:0] din,
    output logic [WORD_W-1:0] dout
`ifdef GBUFF_PARITY_EN
    ,
    output logic              par_err
`endif
);

`ifdef GBUFF_PARITY_EN
    localparam int MEM_W = WORD_W + 1;
`else
    localparam int MEM_W = WORD_W;
`endif

    logic [MEM_W-1:0] mem [DEPTH];
    logic [MEM_W-1:0] wr_word;

`ifdef GBUFF_PARITY_EN
    assign wr_word = {^din, din};
`else
    assign wr_word = din;
`endif

    always_ff @(posedge clk) begin
        if (en && we) begin
            mem[addr] <= wr_word;
        end
    end

    // Read-first: a same-cycle write is not visible until the next read
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dout <= '0;
        end else if (en) begin
            dout <= mem[addr][WORD_W-1:0];
        end
    end

`ifdef GBUFF_PARITY_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            par_err <= 1'b0;
        end else if (en && (^mem[addr])) begin
            par_err <= 1'b1;
        end
    end
`endif

endmodule

// File: rtl/gbuff_hub.sv
// rtl/gbuff_hub.sv - multi-bank global buffer with host burst port; optional parity via GBUFF_PARITY_EN
module gbuff_hub
    import gbuff_hub_pkg::*;
#(
    parameter int NUM_CH = 3,
    parameter int WORD_W = GB_WORD_W,
    parameter int DEPTH  = GB_DEPTH,
    parameter int ADDR_W = $clog2(DEPTH),
    parameter int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_CH-1:0]        tpu_wr_en,
    input  logic [NUM_CH*ADDR_W-1:0] tpu_index,
    input  logic [NUM_CH*WORD_W-1:0] tpu_din,
    output logic [NUM_CH*WORD_W-1:0] tpu_dout,
    output logic [NUM_CH-1:0]        tpu_stall,
    input  logic                     host_start,
    input  logic                     host_dir,
    input  logic [CH_W-1:0]          host_ch,
    input  logic [ADDR_W-1:0]        host_base,
    input  logic [ADDR_W:0]          host_len,
    input  logic [WORD_W-1:0]        host_wdata,
    input  logic                     host_wvalid,
    output logic                     host_wready,
    output logic [WORD_W-1:0]        host_rdata,
    output logic                     host_rvalid,
    input  logic                     host_rready,
    output logic                     host_busy,
    output logic                     host_done,
    output logic                     host_err
`ifdef GBUFF_PARITY_EN
    ,
    output logic [NUM_CH-1:0]        par_err
`endif
);

    localparam logic [ADDR_W:0] CNT_ONE = 1;

    hub_state_t         state;
    logic [CH_W-1:0]    ch_q;
    logic [ADDR_W-1:0]  base_q;
    logic [ADDR_W:0]    len_q;
    logic [ADDR_W:0]    cnt;
    logic [ADDR_W:0]    pop_cnt;

    logic               inflight;
    logic [1:0]         fifo_cnt;
    logic [WORD_W-1:0]  fifo_q [2];

    logic [NUM_CH-1:0]  own;
    logic [WORD_W-1:0]  bank_dout [NUM_CH];
    logic [WORD_W-1:0]  dump_word;
    logic [ADDR_W-1:0]  host_addr;
    logic               host_wr;
    logic               pop;
    logic               issue;
    logic [2:0]         occupancy;

    assign host_busy   = (state != IDLE);
    assign host_wready = (state == LOAD);
    assign host_rvalid = (fifo_cnt != 2'd0);
    assign host_rdata  = fifo_q[0];
    assign tpu_stall   = own;

    assign host_addr = base_q + cnt[ADDR_W-1:0];
    assign host_wr   = (state == LOAD) && host_wvalid;
    assign pop       = host_rvalid && host_rready;

    // Room check counts the read already in the bank pipeline and credits a same-cycle pop
    assign occupancy = {1'b0, fifo_cnt} + {2'b00, inflight} - {2'b00, pop};
    assign issue     = (state == DUMP) && (cnt < len_q) && (occupancy < 3'd2);

    always_comb begin
        dump_word = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (ch_q == CH_W'(c)) begin
                dump_word = bank_dout[c];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            ch_q      <= '0;
            base_q    <= '0;
            len_q     <= '0;
            cnt       <= '0;
            pop_cnt   <= '0;
            host_done <= 1'b0;
            host_err  <= 1'b0;
        end else begin
            host_done <= 1'b0;
            host_err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (host_start) begin
                        if (int'(host_ch) >= NUM_CH) begin
                            host_err <= 1'b1;
                        end else begin
                            ch_q    <= host_ch;
                            base_q  <= host_base;
                            len_q   <= host_len;
                            cnt     <= '0;
                            pop_cnt <= '0;
                            if (host_len == '0) begin
                                state     <= DONE;
                                host_done <= 1'b1;
                            end else if (host_dir == DIR_DUMP) begin
                                state <= DUMP;
                            end else begin
                                state <= LOAD;
                            end
                        end
                    end
                end
                LOAD: begin
                    if (host_wvalid) begin
                        cnt <= cnt + CNT_ONE;
                        if (cnt + CNT_ONE == len_q) begin
                            state     <= DONE;
                            host_done <= 1'b1;
                        end
                    end
                end
                DUMP: begin
                    if (issue) begin
                        cnt <= cnt + CNT_ONE;
                    end
                    if (pop) begin
                        pop_cnt <= pop_cnt + CNT_ONE;
                        if (pop_cnt + CNT_ONE == len_q) begin
                            state     <= DONE;
                            host_done <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            inflight  <= 1'b0;
            fifo_cnt  <= 2'd0;
            fifo_q[0] <= '0;
            fifo_q[1] <= '0;
        end else begin
            inflight <= issue;
            case ({inflight, pop})
                2'b10: begin
                    if (fifo_cnt == 2'd0) fifo_q[0] <= dump_word;
                    else                  fifo_q[1] <= dump_word;
                    fifo_cnt <= fifo_cnt + 2'd1;
                end
                2'b01: begin
                    fifo_q[0] <= fifo_q[1];
                    fifo_cnt  <= fifo_cnt - 2'd1;
                end
                2'b11: begin
                    if (fifo_cnt == 2'd2) begin
                        fifo_q[0] <= fifo_q[1];
                        fifo_q[1] <= dump_word;
                    end else begin
                        fifo_q[0] <= dump_word;
                    end
                end
                default: ;
            endcase
        end
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_bank
        logic              b_en;
        logic              b_we;
        logic [ADDR_W-1:0] b_addr;
        logic [WORD_W-1:0] b_din;
        logic              src_q;
        logic [WORD_W-1:0] hold_q;

        assign own[c] = host_busy && (ch_q == CH_W'(c));

        always_comb begin
            if (own[c]) begin
                b_en   = host_wr | issue;
                b_we   = host_wr;
                b_addr = host_addr;
                b_din  = host_wdata;
            end else begin
                b_en   = 1'b1;
                b_we   = tpu_wr_en[c];
                b_addr = tpu_index[c*ADDR_W +: ADDR_W];
                b_din  = tpu_din[c*WORD_W +: WORD_W];
            end
        end

        gbuff_bank #(
            .WORD_W (WORD_W),
            .DEPTH  (DEPTH),
            .ADDR_W (ADDR_W)
        ) u_bank (
            .clk     (clk),
            .rst     (rst),
            .en      (b_en),
            .we      (b_we),
            .addr    (b_addr),
            .din     (b_din),
            .dout    (bank_dout[c])
`ifdef GBUFF_PARITY_EN
            ,
            .par_err (par_err[c])
`endif
        );

        // Bank output is shared with dump reads, so the TPU view freezes while the host owns the bank
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                src_q  <= 1'b1;
                hold_q <= '0;
            end else begin
                src_q  <= !own[c];
                hold_q <= tpu_dout[c*WORD_W +: WORD_W];
            end
        end

        assign tpu_dout[c*WORD_W +: WORD_W] = src_q ? bank_dout[c] : hold_q;
    end

endmodule

// File: tb/tb_gbuff_hub.sv
// tb/tb_gbuff_hub.sv - directed self-checking bench for gbuff_hub
module tb_gbuff_hub;

    localparam int NC = 3;
    localparam int WW = 32;
    localparam int AW = 8;
    localparam int CW = 2;

    logic             clk;
    logic             rst;
    logic [NC-1:0]    tpu_wr_en;
    logic [NC*AW-1:0] tpu_index;
    logic [NC*WW-1:0] tpu_din;
    logic [NC*WW-1:0] tpu_dout;
    logic [NC-1:0]    tpu_stall;
    logic             host_start;
    logic             host_dir;
    logic [CW-1:0]    host_ch;
    logic [AW-1:0]    host_base;
    logic [AW:0]      host_len;
    logic [WW-1:0]    host_wdata;
    logic             host_wvalid;
    logic             host_wready;
    logic [WW-1:0]    host_rdata;
    logic             host_rvalid;
    logic             host_rready;
    logic             host_busy;
    logic             host_done;
    logic             host_err;
`ifdef GBUFF_PARITY_EN
    logic [NC-1:0]    par_err;
`endif

    int checks = 0;
    int errors = 0;
    int k;
    logic [WW-1:0] rd;

    gbuff_hub dut (
        .clk         (clk),
        .rst         (rst),
        .tpu_wr_en   (tpu_wr_en),
        .tpu_index   (tpu_index),
        .tpu_din     (tpu_din),
        .tpu_dout    (tpu_dout),
        .tpu_stall   (tpu_stall),
        .host_start  (host_start),
        .host_dir    (host_dir),
        .host_ch     (host_ch),
        .host_base   (host_base),
        .host_len    (host_len),
        .host_wdata  (host_wdata),
        .host_wvalid (host_wvalid),
        .host_wready (host_wready),
        .host_rdata  (host_rdata),
        .host_rvalid (host_rvalid),
        .host_rready (host_rready),
        .host_busy   (host_busy),
        .host_done   (host_done),
        .host_err    (host_err)
`ifdef GBUFF_PARITY_EN
        ,
        .par_err     (par_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tpu_write(input int ch, input int idx, input logic [WW-1:0] d);
        tpu_wr_en[ch]           = 1'b1;
        tpu_index[ch*AW +: AW]  = AW'(idx);
        tpu_din[ch*WW +: WW]    = d;
        tick();
        tpu_wr_en[ch]           = 1'b0;
    endtask

    task automatic tpu_read(input int ch, input int idx, output logic [WW-1:0] d);
        tpu_index[ch*AW +: AW] = AW'(idx);
        tick();
        d = tpu_dout[ch*WW +: WW];
    endtask

    task automatic host_req(input logic dir, input int ch, input int base, input int len);
        host_start = 1'b1;
        host_dir   = dir;
        host_ch    = CW'(ch);
        host_base  = AW'(base);
        host_len   = (AW+1)'(len);
        tick();
        host_start = 1'b0;
    endtask

    initial begin
        rst = 1'b0;
        tpu_wr_en = '0; tpu_index = '0; tpu_din = '0;
        host_start = 1'b0; host_dir = 1'b0; host_ch = '0; host_base = '0; host_len = '0;
        host_wdata = '0; host_wvalid = 1'b0; host_rready = 1'b0;
        tick(); tick();
        chk("reset_outputs", {tpu_dout, tpu_stall, host_busy, host_done, host_err, host_rvalid, host_wready},
            '0);
`ifdef GBUFF_PARITY_EN
        chk("reset_par_err", par_err, 3'b000);
`endif
        rst = 1'b1;
        tick();

        // TPU-only access, plus read-during-write returning old data
        tpu_write(0, 5, 32'h1111_1111);
        tpu_write(2, 5, 32'h2222_2222);
        tpu_write(1, 5, 32'hDEAD_BEEF);
        tpu_index = {AW'(5), AW'(5), AW'(5)};
        tick();
        chk("tpu_rd_ch1", tpu_dout[1*WW +: WW], 32'hDEAD_BEEF);
        chk("tpu_rd_ch0", tpu_dout[0*WW +: WW], 32'h1111_1111);
        chk("tpu_rd_ch2", tpu_dout[2*WW +: WW], 32'h2222_2222);
        tpu_write(1, 5, 32'hCAFE_F00D);
        chk("tpu_rdw_old", tpu_dout[1*WW +: WW], 32'hDEAD_BEEF);
        tick();
        chk("tpu_rdw_new", tpu_dout[1*WW +: WW], 32'hCAFE_F00D);

        // Load with wrap-around on channel 2
        chk("load_pre_stall", tpu_stall, 3'b000);
        host_wvalid = 1'b1;
        host_wdata  = 32'd1;
        host_req(1'b0, 2, 254, 4);
        chk("load_busy", {host_busy, tpu_stall, host_wready}, {1'b1, 3'b100, 1'b1});
        for (int i = 1; i <= 4; i++) begin
            host_wdata = WW'(i);
            tick();
            if (i == 3) chk("load_no_early_done", host_done, 1'b0);
        end
        host_wvalid = 1'b0;
        chk("load_done", {host_done, tpu_stall, host_busy}, {1'b1, 3'b100, 1'b1});
        tick();
        chk("load_idle", {host_done, tpu_stall, host_busy}, {1'b0, 3'b000, 1'b0});
        tpu_read(2, 254, rd); chk("wrap_254", rd, 32'd1);
        tpu_read(2, 255, rd); chk("wrap_255", rd, 32'd2);
        tpu_read(2, 0, rd);   chk("wrap_0", rd, 32'd3);
        tpu_read(2, 1, rd);   chk("wrap_1", rd, 32'd4);

        // Load 10..17 into ch 0 while the TPU tries to write ch 0 and ch 1 index 3
        host_wvalid = 1'b1;
        host_wdata  = 32'd10;
        host_req(1'b0, 0, 0, 8);
        for (int i = 0; i < 8; i++) begin
            host_wdata = WW'(10 + i);
            if (i == 5) begin
                tpu_wr_en = 3'b011;
                tpu_index[0*AW +: AW] = AW'(3);
                tpu_index[1*AW +: AW] = AW'(3);
                tpu_din[0*WW +: WW] = 32'h55;
                tpu_din[1*WW +: WW] = 32'h55;
            end
            tick();
            tpu_wr_en = '0;
            if (i == 2) chk("stall_hold_dout0", tpu_dout[0*WW +: WW], 32'h1111_1111);
        end
        host_wvalid = 1'b0;
        chk("coll_done", host_done, 1'b1);
        tick();
        tpu_read(1, 3, rd);
        chk("coll_ch1_write", rd, 32'h55);

        // Dump ch 0 with rready toggling every cycle
        host_req(1'b1, 0, 0, 8);
        chk("dump_rvalid_t1", host_rvalid, 1'b0);
        tick();
        chk("dump_rvalid_t2", host_rvalid, 1'b0);
        tick();
        chk("dump_first", {host_rvalid, host_rdata}, {1'b1, 32'd10});
        k = 0;
        for (int n = 0; n < 100 && k < 8; n++) begin
            host_rready = n[0];
            if (host_rvalid && host_rready) begin
                chk("dump_word", host_rdata, WW'(10 + k));
                k++;
            end
            tick();
        end
        host_rready = 1'b0;
        chk("dump_count", k, 8);
        chk("dump_done", {host_done, host_rvalid}, {1'b1, 1'b0});
        tick();
        chk("dump_idle", {host_done, host_busy}, 2'b00);

        // Rejected channel
        host_req(1'b0, 3, 0, 4);
        chk("reject_err", {host_err, host_busy, tpu_stall}, {1'b1, 1'b0, 3'b000});
        tick();
        chk("reject_clear", {host_err, host_busy}, 2'b00);

        // Zero-length burst on ch 1 at base 3
        host_wvalid = 1'b1;
        host_wdata  = 32'hFFFF_FFFF;
        host_req(1'b0, 1, 3, 0);
        chk("len0_done", {host_done, host_busy, tpu_stall}, {1'b1, 1'b1, 3'b010});
        host_wvalid = 1'b0;
        tick();
        chk("len0_idle", {host_done, host_busy}, 2'b00);
        tpu_read(1, 3, rd);
        chk("len0_no_write", rd, 32'h55);

        // Reset in the middle of a dump
        host_rready = 1'b1;
        host_req(1'b1, 0, 0, 8);
        k = 0;
        for (int n = 0; n < 20 && k < 3; n++) begin
            if (host_rvalid) k++;
            tick();
        end
        chk("mid_count", k, 3);
        #2 rst = 1'b0;
        #1;
        chk("mid_reset_outputs", {tpu_dout, tpu_stall, host_busy, host_done, host_err, host_rvalid, host_wready},
            '0);
        host_rready = 1'b0;
        tick(); tick();
        rst = 1'b1;
        for (int n = 0; n < 3; n++) begin
            tick();
            chk("mid_no_done", {host_done, host_busy}, 2'b00);
        end
        tpu_read(0, 0, rd); chk("mid_data_0", rd, 32'd10);
        tpu_read(0, 7, rd); chk("mid_data_7", rd, 32'd17);

`ifdef GBUFF_PARITY_EN
        tpu_write(0, 9, 32'h0000_0F0F);
        chk("par_clean", par_err, 3'b000);
        dut.g_bank[0].u_bank.mem[9][0] = ~dut.g_bank[0].u_bank.mem[9][0];
        tpu_read(0, 9, rd);
        chk("par_flip", par_err, 3'b001);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/gbuff_hub.md
# gbuff_hub

Parametrised multi-channel global-buffer hub replacing the three fixed, independent word buffers (A, B, OUT) beside the TPU core with `NUM_CH` single-port banks. Each bank has a configurable width and depth. A shared host burst port can load any bank from a valid/ready stream or dump any bank to one, with full throughput. The TPU keeps one synchronous port per bank; a host burst on a bank takes that bank's port, and the TPU is told via a per-channel stall.

## Interface
- `NUM_CH`, default 3: number of banks / TPU channels.
- `WORD_W`, default 32: bits per word.
- `DEPTH`, default 256: words per bank; must be a power of two.
- `ADDR_W`, default `$clog2(DEPTH)`: index width.
- `CH_W`, default `$clog2(NUM_CH)` (minimum 1): host channel-select width.

Ports:
- `clk`, in, 1: the only clock.
- `rst`, in, 1: asynchronous, active-low reset.
- `tpu_wr_en`, in, `NUM_CH`: per-channel write enable.
- `tpu_index`, in, `NUM_CH*ADDR_W`: per-channel address; channel c occupies slice `[c*ADDR_W +: ADDR_W]`.
- `tpu_din`, in, `NUM_CH*WORD_W`: per-channel write data.
- `tpu_dout`, out, `NUM_CH*WORD_W`: per-channel registered read data.
- `tpu_stall`, out, `NUM_CH`: bank is owned by a host burst.
- `host_start`, in, 1: one-cycle burst request.
- `host_dir`, in, 1: 0 = load (host to bank), 1 = dump (bank to host).
- `host_ch`, in, `CH_W`: target bank.
- `host_base`, in, `ADDR_W`: first address of the burst.
- `host_len`, in, `ADDR_W+1`: burst length in words; valid range 0..`DEPTH`.
- `host_wdata`, in, `WORD_W`; `host_wvalid`, in, 1; `host_wready`, out, 1: load stream.
- `host_rdata`, out, `WORD_W`; `host_rvalid`, out, 1; `host_rready`, in, 1: dump stream.
- `host_busy`, out, 1: a burst is in progress.
- `host_done`, out, 1: one-cycle pulse when a burst completes.
- `host_err`, out, 1: one-cycle pulse when a request is rejected.
- `par_err`, out, `NUM_CH`: parity error flag; present only when `GBUFF_PARITY_EN` is defined.

## Operation
- FSM states: `IDLE`, `LOAD`, `DUMP`, `DONE`.
- Leaving `IDLE`:
  - `host_start` with `host_ch` ≥ `NUM_CH`: stay in `IDLE`, pulse `host_err`.
  - `host_len`=0: go directly to `DONE`; no bank access.
  - Otherwise go to `LOAD` or `DUMP` per `host_dir`. Latch channel, base and length; clear the word counter `cnt`.
- `host_start` while not in `IDLE` is ignored; no error is raised.
- `LOAD`:
  - `host_wready`=1.
  - Each cycle with `host_wvalid`: write `host_wdata` to address `(base+cnt) mod DEPTH`, then increment `cnt`.
  - When `cnt` reaches `len`, go to `DONE`.
- `DUMP`:
  - Reads are issued from `(base+cnt) mod DEPTH` into a 2-entry skid FIFO.
  - A read is issued only when the FIFO has room counting in-flight reads.
  - `host_rvalid` = FIFO not empty; `host_rdata` = FIFO head; the head pops on `host_rvalid & host_rready`.
  - When all `len` words have been popped, go to `DONE`.
- `DONE`: pulse `host_done` for one cycle, then return to `IDLE`.
- Ownership:
  - `tpu_stall[c]`=1 and `host_busy`=1 from the cycle after acceptance through `DONE` inclusive.
  - While stalled, TPU writes to bank c are dropped and `tpu_dout[c]` holds its last value.
  - Other banks keep full TPU access.
- Arithmetic: address wrap-around is modulo `DEPTH`. `host_len`=`DEPTH` covers the whole bank exactly once.
- Reset:
  - All outputs go to 0 and the FSM to `IDLE`; the FIFO is emptied.
  - Bank contents are not reset.
  - Reset mid-burst abandons the burst with no `host_done`.

## Timing
- TPU write: takes effect on the `clk` edge where `tpu_wr_en[c]`=1.
- TPU read: data from the address presented at edge N appears on `tpu_dout` after edge N. A read and write to the same address in one cycle returns the old data.
- Host acceptance: the `IDLE`→burst transition occurs on the edge that samples `host_start`.
- Load throughput: one word per cycle.
- Dump latency: first `host_rvalid` 2 cycles after acceptance. Sustained one word per cycle while `host_rready`=1.
- Completion: `host_done` asserts the cycle after the last transfer.

## Configuration
- `GBUFF_PARITY_EN` defined:
  - Each bank stores `WORD_W+1` bits, the extra bit being even parity over the word.
  - Every read (TPU or dump) recomputes parity; on mismatch, `par_err[c]` is set.
  - `par_err[c]` is sticky until reset.
- Not defined: banks are `WORD_W` bits wide and the `par_err` port is absent.

## Structure
- Shared package holds:
  - FSM state enum;
  - direction constants (`DIR_LOAD`=0, `DIR_DUMP`=1);
  - the default `WORD_W` and `DEPTH` values, aligned with the existing word-size and buffer-index definitions.
- One sub-module, `gbuff_bank`:
  - single-port synchronous RAM with registered output;
  - parity slice when `GBUFF_PARITY_EN` is defined;
  - instantiated `NUM_CH` times in a generate loop.
- The hub owns the FSM, skid FIFO and per-bank port muxes.

## Test plan
- TPU-only access: channel 1 writes 0xDEADBEEF at index 5, then reads index 5. Expect `tpu_dout[1]`=0xDEADBEEF one cycle later; channels 0 and 2 are unaffected.
- Load with wrap-around: ch 2, base 254, len 4 (`DEPTH`=256), words 1..4 streamed with `wvalid` held high. Expect indices 254, 255, 0, 1 to hold 1..4; `host_done` 1 cycle after the 4th word; `tpu_stall[2]` high only during the burst.
- Dump under backpressure: ch 0 holding 10..17 at 0..7, len 8, `rready` toggling every cycle. Expect the stream 10..17 in order with no loss or duplication, then `host_done`.
- Collision: during a load to ch 0, the TPU writes 0x55 to ch 0 index 3 and to ch 1 index 3. Expect the ch 0 write dropped and ch 1 index 3 = 0x55.
- Rejection and edge cases:
  - `host_ch`=3 with `NUM_CH`=3: expect a `host_err` pulse and the FSM stays `IDLE`.
  - `host_len`=0: expect `host_done` 1 cycle after acceptance with no writes.
- Reset mid-dump: assert `rst` low after 3 of 8 words. Expect all outputs 0 and `host_busy`=0 immediately, no `host_done`, and bank data intact. With `GBUFF_PARITY_EN` defined, a forced parity flip sets `par_err`.
